// File: rtl/cla_add_pipe_if.sv
// rtl/cla_add_pipe_if.sv - operand/result handshake bundle for cla_add_pipe
//
// Signals (slave = adder side):
//   in_valid/in_ready   operation handshake, accepted when both high
//   a, b                operands, WIDTH bits
//   cin                 carry-in for add, ignored for subtract
//   sub                 0: a + b + cin, 1: a - b
//   out_valid/out_ready result handshake, consumed when both high
//   sum                 result modulo 2^WIDTH
//   cout                carry out of the MSB (1 = no borrow when subtracting)
//   ovf                 two's-complement overflow

interface cla_add_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_add_pipe.sv
// rtl/cla_add_pipe.sv - pipelined carry-lookahead adder/subtractor, one SEG-bit slice per stage
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cla_add_pipe_if.slave: operand handshake in, result handshake out
//
// Stage s (register index s = 0..NSEG-1) holds the result of lookahead slice s.
// Operands are stored right-shifted so the next slice to process is always in
// bits [SEG-1:0]; completed sum slices accumulate in place so the final stage
// presents the whole word aligned.

module cla_add_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_add_pipe_if.slave  bus
);

    localparam int NSEG = WIDTH / SEG;

    if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_params
        $error("cla_add_pipe: WIDTH must be a positive multiple of SEG");
    end

    // Carries of one slice in sum-of-products lookahead form:
    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c[0]
    function automatic logic [SEG:0] cla_carries(
        input logic [SEG-1:0] g,
        input logic [SEG-1:0] p,
        input logic           c_in
    );
        logic [SEG:0] c;
        logic         acc;
        logic         prod;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & c_in);
        end
        return c;
    endfunction

    // Per-stage pipeline registers
    logic             valid_d [NSEG];
    logic             valid_q [NSEG];
    logic             carry_d [NSEG];
    logic             carry_q [NSEG];
    logic [WIDTH-1:0] sum_d   [NSEG];
    logic [WIDTH-1:0] sum_q   [NSEG];
    logic [WIDTH-1:0] op_a_d  [NSEG];
    logic [WIDTH-1:0] op_a_q  [NSEG];
    logic [WIDTH-1:0] op_b_d  [NSEG];
    logic [WIDTH-1:0] op_b_q  [NSEG];
    logic             ovf_d;
    logic             ovf_q;

    // Combinational working values for the stage being evaluated
    logic             advance;
    logic [WIDTH-1:0] st_a;
    logic [WIDTH-1:0] st_b;
    logic [WIDTH-1:0] st_sum;
    logic             st_c;
    logic             st_v;
    logic [SEG-1:0]   sl_g;
    logic [SEG-1:0]   sl_p;
    logic [SEG-1:0]   sl_s;
    logic [SEG:0]     sl_c;

    always_comb begin
        // The whole pipeline moves as one; a stalled output freezes every stage.
        advance = !valid_q[NSEG-1] || bus.out_ready;

        ovf_d  = ovf_q;
        st_a   = '0;
        st_b   = '0;
        st_sum = '0;
        st_c   = 1'b0;
        st_v   = 1'b0;
        sl_g   = '0;
        sl_p   = '0;
        sl_s   = '0;
        sl_c   = '0;
        for (int s = 0; s < NSEG; s++) begin
            valid_d[s] = valid_q[s];
            carry_d[s] = carry_q[s];
            sum_d[s]   = sum_q[s];
            op_a_d[s]  = op_a_q[s];
            op_b_d[s]  = op_b_q[s];
        end

        for (int s = 0; s < NSEG; s++) begin
            if (s == 0) begin
                // Subtraction is a + ~b + 1; cin is overridden so it cannot disturb a - b.
                st_a   = bus.a;
                st_b   = bus.sub ? ~bus.b : bus.b;
                st_c   = bus.sub ? 1'b1 : bus.cin;
                st_sum = '0;
                st_v   = bus.in_valid;
            end else begin
                st_a   = op_a_q[s-1];
                st_b   = op_b_q[s-1];
                st_c   = carry_q[s-1];
                st_sum = sum_q[s-1];
                st_v   = valid_q[s-1];
            end

            sl_g = st_a[SEG-1:0] & st_b[SEG-1:0];
            sl_p = st_a[SEG-1:0] ^ st_b[SEG-1:0];
            sl_c = cla_carries(sl_g, sl_p, st_c);
            sl_s = sl_p ^ sl_c[SEG-1:0];

            if (advance) begin
                valid_d[s] = st_v;
                carry_d[s] = sl_c[SEG];
                sum_d[s]   = st_sum | (WIDTH'(sl_s) << (s * SEG));
                op_a_d[s]  = st_a >> SEG;
                op_b_d[s]  = st_b >> SEG;
                if (s == NSEG - 1) begin
                    // Last slice holds the MSB: overflow is carry-in XOR carry-out of that bit.
                    ovf_d = sl_c[SEG] ^ sl_c[SEG-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEG; s++) begin
                valid_q[s] <= 1'b0;
                carry_q[s] <= 1'b0;
                sum_q[s]   <= '0;
                op_a_q[s]  <= '0;
                op_b_q[s]  <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int s = 0; s < NSEG; s++) begin
                valid_q[s] <= valid_d[s];
                carry_q[s] <= carry_d[s];
                sum_q[s]   <= sum_d[s];
                op_a_q[s]  <= op_a_d[s];
                op_b_q[s]  <= op_b_d[s];
            end
            ovf_q <= ovf_d;
        end
    end

    // The last stage's slice carry-out is the carry out of bit WIDTH-1.
    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[NSEG-1];
    assign bus.sum       = sum_q[NSEG-1];
    assign bus.cout      = carry_q[NSEG-1];
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_add_pipe.sv
// tb/tb_cla_add_pipe.sv - scoreboard bench for cla_add_pipe (WIDTH=16, SEG=4)

module tb_cla_add_pipe;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cla_add_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_add_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          id;
        int          push_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_pops   = 0;
    int   next_id  = 0;
    int   stall_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: one wide add of the effective operands, overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [15:0] beff;
        logic [16:0] full;
        beff       = sub ? ~b : b;
        full       = {1'b0, a} + {1'b0, beff} + {16'b0, (sub ? 1'b1 : cin)};
        e.sum      = full[15:0];
        e.cout     = full[16];
        e.ovf      = (a[15] == beff[15]) && (full[15] != a[15]);
        e.id       = 0;
        e.push_cyc = 0;
        e.chk_lat  = 1'b0;
        return e;
    endfunction

    // Offers one operation; the expectation is queued only on the edge that accepts it.
    task automatic send(input logic [15:0] a_i, input logic [15:0] b_i,
                        input logic cin_i, input logic sub_i,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input bit lat);
        int   waited;
        exp_t e;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.a        = a_i;
        bus.b        = b_i;
        bus.cin      = cin_i;
        bus.sub      = sub_i;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.sum      = es;
        e.cout     = ec;
        e.ovf      = eo;
        e.id       = next_id;
        e.push_cyc = cyc;
        e.chk_lat  = lat;
        next_id++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input logic [15:0] a_i, input logic [15:0] b_i,
                              input logic cin_i, input logic sub_i);
        exp_t m;
        m = model(a_i, b_i, cin_i, sub_i);
        send(a_i, b_i, cin_i, sub_i, m.sum, m.cout, m.ovf, 1'b0);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compares every consumed result against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum 0x%0h with empty scoreboard, expected no result",
                             bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sum[%0d]", e.id), {16'b0, bus.sum}, {16'b0, e.sum});
                    check($sformatf("cout[%0d]", e.id), {31'b0, bus.cout}, {31'b0, e.cout});
                    check($sformatf("ovf[%0d]", e.id), {31'b0, bus.ovf}, {31'b0, e.ovf});
                    if (e.chk_lat) begin
                        check($sformatf("latency[%0d]", e.id), cyc - e.push_cyc, NSEG);
                    end
                end
                n_pops++;
            end
        end
    end

    // Backpressure: three refused cycles right after the 5th streaming result is consumed.
    initial begin : stall_ctrl
        wait (stall_at >= 0 && n_pops == stall_at);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_in_ready[%0d]", i), {31'b0, bus.in_ready}, 0);
            check($sformatf("stall_out_valid[%0d]", i), {31'b0, bus.out_valid}, 1);
            if (exp_q.size() > 0) begin
                check($sformatf("stall_held_sum[%0d]", i), {16'b0, bus.sum}, {16'b0, exp_q[0].sum});
                check($sformatf("stall_held_flags[%0d]", i), {30'b0, bus.cout, bus.ovf},
                      {30'b0, exp_q[0].cout, exp_q[0].ovf});
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL stall_scoreboard: got empty scoreboard during stall, expected a pending result");
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    end

    initial begin : main
        int pops_before;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_sum", {16'b0, bus.sum}, 0);
        check("rst_cout", {31'b0, bus.cout}, 0);
        check("rst_ovf", {31'b0, bus.ovf}, 0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, back to back, with hand-computed results.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        drain("drain_directed", 50);

        // Reset while operations are in flight and the first is at the output.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'h4444, 16'h1111, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        send(16'h9000, 16'h0001, 1'b0, 1'b1, 16'h8FFF, 1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 0);
        check("midrst_sum", {16'b0, bus.sum}, 0);
        check("midrst_cout", {31'b0, bus.cout}, 0);
        check("midrst_ovf", {31'b0, bus.ovf}, 0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle[%0d]", i), {31'b0, bus.out_valid}, 0);
        end
        @(posedge clk);
        #1;

        // Streaming: 20 back-to-back operations checked against the reference model.
        pops_before = n_pops;
        stall_at    = n_pops + 5;
        for (int i = 0; i < 20; i++) begin
            send_model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        bus.in_valid = 1'b0;
        drain("drain_stream", 100);
        repeat (10) @(negedge clk);
        check("stream_result_count", n_pops - pops_before, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
